// File: rtl/ceres_clint.sv
// ceres_clint: multi-hart core-local interruptor for the CERES SoC.
// Provides one shared prescaled 64-bit mtime, plus a per-hart mtimecmp and msip,
// behind a registered valid/ready port with one outstanding response.
module ceres_clint #(
  parameter int unsigned NUM_HARTS    = 1,
  parameter int unsigned TICK_DIV     = 1,
  parameter logic [63:0] MTIMECMP_RST = '1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [15:0]          req_addr_i,
  input  logic                 req_we_i,
  input  logic [31:0]          req_wdata_i,
  input  logic [3:0]           req_wstrb_i,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic [31:0]          res_rdata_o,
  output logic                 res_err_o,
  output logic [NUM_HARTS-1:0] mtip_o,
  output logic [NUM_HARTS-1:0] msip_o
);

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

  logic [15:0]          presc_q, presc_d;
  logic                 tick;
  logic [63:0]          mtime_q, mtime_d;
  logic [63:0]          mtimecmp_q [NUM_HARTS];
  logic [63:0]          mtimecmp_d [NUM_HARTS];
  logic [NUM_HARTS-1:0] msip_q, msip_d;
  logic [NUM_HARTS-1:0] mtip_q, mtip_d;
  logic                 res_valid_q, res_valid_d;
  logic                 res_err_q, res_err_d;
  logic [31:0]          res_rdata_q, res_rdata_d;

  logic                 accept;
  logic                 wrEn;
  logic [NUM_HARTS-1:0] msipSel;
  logic [NUM_HARTS-1:0] cmpSel;
  logic [12:0]          cmpIdx;
  logic                 cmpUpper;
  logic                 mtimeLoSel;
  logic                 mtimeHiSel;
  logic                 mapped;
  logic [31:0]          readData;
  logic                 unusedAddrBits;

  // The two lowest address bits select a byte inside a word and carry no meaning here.
  assign unusedAddrBits = ^req_addr_i[1:0];

  // Byte-lane merge: lanes with a clear strobe keep their old contents.
  function automatic logic [31:0] mergeBytes(input logic [31:0] oldVal,
                                             input logic [31:0] newVal,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = oldVal;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = newVal[8*b +: 8];
    end
    return res;
  endfunction

  // Only one response may be outstanding; a consumed response frees the slot in the same cycle.
  assign req_ready_o = ~res_valid_q | res_ready_i;
  assign accept      = req_valid_i & req_ready_o;
  assign wrEn        = accept & req_we_i & (|req_wstrb_i);

  // Address decode: hart-indexed msip and mtimecmp windows, plus the two mtime words.
  always_comb begin
    msipSel    = '0;
    cmpSel     = '0;
    cmpIdx     = req_addr_i[15:3] - 13'h0800;
    cmpUpper   = req_addr_i[2];
    mtimeLoSel = (req_addr_i[15:2] == 14'h2FFE);
    mtimeHiSel = (req_addr_i[15:2] == 14'h2FFF);
    for (int h = 0; h < NUM_HARTS; h++) begin
      msipSel[h] = (req_addr_i[15:14] == 2'b00) && (req_addr_i[13:2] == 12'(h));
      cmpSel[h]  = (req_addr_i[15:14] != 2'b00) && (req_addr_i[15:2] < 14'h2FFE) &&
                   (cmpIdx == 13'(h));
    end
    mapped = (|msipSel) | (|cmpSel) | mtimeLoSel | mtimeHiSel;
  end

  // Read mux over the current register contents; unmapped offsets read as zero.
  always_comb begin
    readData = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (msipSel[h]) readData = {31'b0, msip_q[h]};
      if (cmpSel[h])  readData = cmpUpper ? mtimecmp_q[h][63:32] : mtimecmp_q[h][31:0];
    end
    if (mtimeLoSel) readData = mtime_q[31:0];
    if (mtimeHiSel) readData = mtime_q[63:32];
  end

  // Timer state: prescaler, mtime with write-over-tick priority, per-hart compare and msip.
  always_comb begin
    tick    = (presc_q == TICK_LAST);
    presc_d = tick ? 16'd0 : presc_q + 16'd1;
    mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
    if (wrEn && mtimeLoSel) begin
      mtime_d = {mtime_q[63:32], mergeBytes(mtime_q[31:0], req_wdata_i, req_wstrb_i)};
    end else if (wrEn && mtimeHiSel) begin
      mtime_d = {mergeBytes(mtime_q[63:32], req_wdata_i, req_wstrb_i), mtime_q[31:0]};
    end
    for (int h = 0; h < NUM_HARTS; h++) begin
      mtimecmp_d[h] = mtimecmp_q[h];
      msip_d[h]     = msip_q[h];
      if (wrEn && cmpSel[h]) begin
        if (cmpUpper) begin
          mtimecmp_d[h][63:32] = mergeBytes(mtimecmp_q[h][63:32], req_wdata_i, req_wstrb_i);
        end else begin
          mtimecmp_d[h][31:0] = mergeBytes(mtimecmp_q[h][31:0], req_wdata_i, req_wstrb_i);
        end
      end
      if (wrEn && msipSel[h] && req_wstrb_i[0]) msip_d[h] = req_wdata_i[0];
      mtip_d[h] = (mtime_d >= mtimecmp_d[h]);
    end
  end

  // Response slot: load on accept, clear once consumed, otherwise hold stable.
  always_comb begin
    res_valid_d = res_valid_q;
    res_rdata_d = res_rdata_q;
    res_err_d   = res_err_q;
    if (accept) begin
      res_valid_d = 1'b1;
      res_rdata_d = req_we_i ? 32'd0 : readData;
      res_err_d   = ~mapped;
    end else if (res_ready_i) begin
      res_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc_q     <= '0;
      mtime_q     <= '0;
      msip_q      <= '0;
      mtip_q      <= '0;
      res_valid_q <= 1'b0;
      res_rdata_q <= '0;
      res_err_q   <= 1'b0;
      for (int h = 0; h < NUM_HARTS; h++) mtimecmp_q[h] <= MTIMECMP_RST;
    end else begin
      presc_q     <= presc_d;
      mtime_q     <= mtime_d;
      msip_q      <= msip_d;
      mtip_q      <= mtip_d;
      res_valid_q <= res_valid_d;
      res_rdata_q <= res_rdata_d;
      res_err_q   <= res_err_d;
      for (int h = 0; h < NUM_HARTS; h++) mtimecmp_q[h] <= mtimecmp_d[h];
    end
  end

  assign res_valid_o = res_valid_q;
  assign res_rdata_o = res_rdata_q;
  assign res_err_o   = res_err_q;
  assign mtip_o      = mtip_q;
  assign msip_o      = msip_q;

endmodule

// File: tb/tb_ceres_clint.sv
// tb_ceres_clint: directed and randomized bench for ceres_clint with a
// cycle-level behavioural model of the CLINT register map and timer.
module tb_ceres_clint;

  localparam int NH = 2;
  localparam int DIV = 4;
  localparam logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  logic          clk;
  logic          rst;
  logic          reqValid;
  logic          reqReady;
  logic [15:0]   reqAddr;
  logic          reqWe;
  logic [31:0]   reqWdata;
  logic [3:0]    reqWstrb;
  logic          resValid;
  logic          resReady;
  logic [31:0]   resRdata;
  logic          resErr;
  logic [NH-1:0] mtipO;
  logic [NH-1:0] msipO;

  int total = 0;
  int bad = 0;

  // Reference model state
  logic [63:0]   mMtime;
  logic [63:0]   mCmp [NH];
  logic [NH-1:0] mMsip;
  logic [NH-1:0] mMtip;
  logic          mResValid;
  logic [31:0]   mResRdata;
  logic          mResErr;
  int unsigned   kCycle;

  logic [15:0] addrTab [14] = '{16'h0000, 16'h0004, 16'h0008, 16'h4000, 16'h4004,
                                16'h4008, 16'h400C, 16'h4010, 16'hBFF8, 16'hBFFC,
                                16'h1000, 16'hBFF0, 16'hC000, 16'h3FFC};

  ceres_clint #(
    .NUM_HARTS(NH),
    .TICK_DIV(DIV),
    .MTIMECMP_RST(CMP_RST)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .req_valid_i(reqValid),
    .req_ready_o(reqReady),
    .req_addr_i(reqAddr),
    .req_we_i(reqWe),
    .req_wdata_i(reqWdata),
    .req_wstrb_i(reqWstrb),
    .res_valid_o(resValid),
    .res_ready_i(resReady),
    .res_rdata_o(resRdata),
    .res_err_o(resErr),
    .mtip_o(mtipO),
    .msip_o(msipO)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] a, input logic we,
                               input logic [31:0] wd, input logic [3:0] ws, input logic rr);
    reqValid = v;
    reqAddr  = a;
    reqWe    = we;
    reqWdata = wd;
    reqWstrb = ws;
    resReady = rr;
  endtask

  // kind: 0 unmapped, 1 msip, 2 mtimecmp, 3 mtime
  function automatic void decode(input logic [15:0] addr, output int kind,
                                 output int hart, output bit upper);
    int a;
    a = int'(addr) & 32'h0000_FFFC;
    kind = 0;
    hart = 0;
    upper = 1'b0;
    if (a == 32'hBFF8 || a == 32'hBFFC) begin
      kind = 3;
      upper = (a == 32'hBFFC);
    end else if (a < 32'h4000) begin
      hart = a / 4;
      if (hart < NH) kind = 1;
    end else if (a < 32'hBFF8) begin
      hart = (a - 32'h4000) / 8;
      upper = ((a - 32'h4000) % 8) == 4;
      if (hart < NH) kind = 2;
    end
  endfunction

  function automatic logic [31:0] laneMerge(input logic [31:0] oldVal, input logic [31:0] wd,
                                            input logic [3:0] st);
    logic [31:0] mask;
    mask = {{8{st[3]}}, {8{st[2]}}, {8{st[1]}}, {8{st[0]}}};
    return (oldVal & ~mask) | (wd & mask);
  endfunction

  // Advance the model by one clock edge using the inputs the DUT is about to sample.
  task automatic modelEdge();
    int kind;
    int hart;
    bit upper;
    bit tick;
    bit accept;
    logic [31:0] rd;
    logic [63:0] nt;
    if (rst) begin
      mMtime = '0;
      for (int h = 0; h < NH; h++) mCmp[h] = CMP_RST;
      mMsip = '0;
      mMtip = '0;
      mResValid = 1'b0;
      mResRdata = '0;
      mResErr = 1'b0;
      kCycle = 0;
      return;
    end
    tick = (kCycle % DIV) == (DIV - 1);
    kCycle++;
    accept = reqValid && (!mResValid || resReady);
    decode(reqAddr, kind, hart, upper);
    rd = '0;
    if (kind == 1) rd = {31'b0, mMsip[hart]};
    if (kind == 2) rd = upper ? mCmp[hart][63:32] : mCmp[hart][31:0];
    if (kind == 3) rd = upper ? mMtime[63:32] : mMtime[31:0];
    nt = tick ? mMtime + 64'd1 : mMtime;
    if (accept && reqWe) begin
      if (kind == 3 && reqWstrb != 4'd0) begin
        if (upper) nt = {laneMerge(mMtime[63:32], reqWdata, reqWstrb), mMtime[31:0]};
        else       nt = {mMtime[63:32], laneMerge(mMtime[31:0], reqWdata, reqWstrb)};
      end
      if (kind == 2) begin
        if (upper) mCmp[hart][63:32] = laneMerge(mCmp[hart][63:32], reqWdata, reqWstrb);
        else       mCmp[hart][31:0]  = laneMerge(mCmp[hart][31:0], reqWdata, reqWstrb);
      end
      if (kind == 1 && reqWstrb[0]) mMsip[hart] = reqWdata[0];
    end
    mMtime = nt;
    for (int h = 0; h < NH; h++) mMtip[h] = (mMtime >= mCmp[h]);
    if (accept) begin
      mResValid = 1'b1;
      mResRdata = reqWe ? 32'd0 : rd;
      mResErr = (kind == 0);
    end else if (resReady) begin
      mResValid = 1'b0;
    end
  endtask

  task automatic compareAll(input string tag);
    checkOutput({tag, "/req_ready"}, 64'(reqReady), 64'(!mResValid || resReady));
    checkOutput({tag, "/res_valid"}, 64'(resValid), 64'(mResValid));
    if (mResValid) begin
      checkOutput({tag, "/res_rdata"}, 64'(resRdata), 64'(mResRdata));
      checkOutput({tag, "/res_err"}, 64'(resErr), 64'(mResErr));
    end
    checkOutput({tag, "/mtip"}, 64'(mtipO), 64'(mMtip));
    checkOutput({tag, "/msip"}, 64'(msipO), 64'(mMsip));
  endtask

  task automatic stepClock(input string tag);
    modelEdge();
    @(posedge clk);
    #1;
    compareAll(tag);
  endtask

  // One complete transaction with res_ready held high; returns observed and modelled response.
  task automatic busOp(input string tag, input logic [15:0] addr, input logic we,
                       input logic [31:0] wdata, input logic [3:0] wstrb,
                       output logic [31:0] rdata, output logic err,
                       output logic [31:0] expRd, output logic expErr);
    int n;
    applyStimulus(1'b1, addr, we, wdata, wstrb, 1'b1);
    n = 0;
    while (!reqReady && n < 20) begin
      stepClock(tag);
      n++;
    end
    stepClock(tag);
    applyStimulus(1'b0, addr, 1'b0, 32'd0, 4'd0, 1'b1);
    checkOutput({tag, "/resp_seen"}, 64'(resValid), 64'd1);
    rdata = resRdata;
    err = resErr;
    expRd = mResRdata;
    expErr = mResErr;
    stepClock(tag);
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1'b0, 16'h0, 1'b0, 32'd0, 4'd0, 1'b1);
    stepClock("reset");
    stepClock("reset");
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic err;
    logic [31:0] expRd;
    logic expErr;
    int n;
    logic [31:0] wd;

    rst = 1'b1;
    applyStimulus(1'b0, 16'h0, 1'b0, 32'd0, 4'd0, 1'b1);
    $display("[TB] starting ceres_clint bench NUM_HARTS=%0d TICK_DIV=%0d", NH, DIV);

    // Reset values
    doReset();
    checkOutput("rst_mtip", 64'(mtipO), 64'd0);
    checkOutput("rst_msip", 64'(msipO), 64'd0);
    checkOutput("rst_res_valid", 64'(resValid), 64'd0);
    checkOutput("rst_rdata", 64'(resRdata), 64'd0);
    checkOutput("rst_err", 64'(resErr), 64'd0);
    busOp("rd_cmp0_lo", 16'h4000, 1'b0, 32'd0, 4'd0, rd, err, expRd, expErr);
    checkOutput("cmp0_lo_rst", 64'(rd), 64'hFFFF_FFFF);
    checkOutput("cmp0_lo_err", 64'(err), 64'd0);
    busOp("rd_cmp0_hi", 16'h4004, 1'b0, 32'd0, 4'd0, rd, err, expRd, expErr);
    checkOutput("cmp0_hi_rst", 64'(rd), 64'hFFFF_FFFF);
    checkOutput("cmp0_hi_err", 64'(err), 64'd0);

    // mtime write then reads
    busOp("wr_mtime", 16'hBFF8, 1'b1, 32'd5, 4'hF, rd, err, expRd, expErr);
    busOp("rd_mtime1", 16'hBFF8, 1'b0, 32'd0, 4'd0, rd, err, expRd, expErr);
    checkOutput("mtime_rd1", 64'(rd), 64'(expRd));
    for (int i = 0; i < 10; i++) stepClock("mtime_wait");
    busOp("rd_mtime2", 16'hBFF8, 1'b0, 32'd0, 4'd0, rd, err, expRd, expErr);
    checkOutput("mtime_rd2", 64'(rd), 64'(expRd));

    // Timer interrupt on hart 1
    doReset();
    busOp("wr_cmp1_hi", 16'h400C, 1'b1, 32'd0, 4'hF, rd, err, expRd, expErr);
    busOp("wr_cmp1_lo", 16'h4008, 1'b1, 32'd3, 4'hF, rd, err, expRd, expErr);
    n = 0;
    while (!mtipO[1] && n < 40) begin
      stepClock("mtip_wait");
      n++;
    end
    checkOutput("mtip1_rise", 64'(mtipO[1]), 64'd1);
    checkOutput("mtip0_low", 64'(mtipO[0]), 64'd0);
    busOp("wr_cmp1_hi1", 16'h400C, 1'b1, 32'd1, 4'hF, rd, err, expRd, expErr);
    checkOutput("mtip1_clear", 64'(mtipO[1]), 64'd0);

    // Software interrupt and byte strobes
    busOp("wr_msip1", 16'h0004, 1'b1, 32'hFFFF_FFFF, 4'h1, rd, err, expRd, expErr);
    checkOutput("msip_set", 64'(msipO), 64'b10);
    checkOutput("msip_wr_rdata", 64'(rd), 64'd0);
    busOp("rd_msip1", 16'h0004, 1'b0, 32'd0, 4'd0, rd, err, expRd, expErr);
    checkOutput("msip_readback", 64'(rd), 64'd1);
    busOp("wr_msip1_s2", 16'h0004, 1'b1, 32'd0, 4'h2, rd, err, expRd, expErr);
    checkOutput("msip_strb2_hold", 64'(msipO), 64'b10);

    // Unmapped accesses
    busOp("rd_hart2", 16'h0008, 1'b0, 32'd0, 4'd0, rd, err, expRd, expErr);
    checkOutput("hart2_rdata", 64'(rd), 64'd0);
    checkOutput("hart2_err", 64'(err), 64'd1);
    busOp("wr_hart2", 16'h0008, 1'b1, 32'hFFFF_FFFF, 4'hF, rd, err, expRd, expErr);
    checkOutput("hart2_wr_err", 64'(err), 64'd1);
    checkOutput("hart2_no_change", 64'(msipO), 64'b10);
    busOp("rd_1000", 16'h1000, 1'b0, 32'd0, 4'd0, rd, err, expRd, expErr);
    checkOutput("off1000_rdata", 64'(rd), 64'd0);
    checkOutput("off1000_err", 64'(err), 64'd1);

    // mtime wrap: high half first so the low half cannot carry before the wrap
    busOp("wr_mtime_hi", 16'hBFFC, 1'b1, 32'hFFFF_FFFF, 4'hF, rd, err, expRd, expErr);
    busOp("wr_mtime_lo", 16'hBFF8, 1'b1, 32'hFFFF_FFFF, 4'hF, rd, err, expRd, expErr);
    for (int i = 0; i < 6; i++) stepClock("wrap_wait");
    busOp("rd_mtime_hi", 16'hBFFC, 1'b0, 32'd0, 4'd0, rd, err, expRd, expErr);
    checkOutput("wrap_hi_zero", 64'(rd), 64'd0);
    busOp("rd_mtime_lo", 16'hBFF8, 1'b0, 32'd0, 4'd0, rd, err, expRd, expErr);
    checkOutput("wrap_lo", 64'(rd), 64'(expRd));

    // Backpressure: hold res_ready low for 5 cycles
    applyStimulus(1'b1, 16'h4008, 1'b0, 32'd0, 4'd0, 1'b0);
    stepClock("hold_acc");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 16'hBFF8, 1'b0, 32'd0, 4'd0, 1'b0);
      stepClock("hold");
      checkOutput("hold_ready", 64'(reqReady), 64'd0);
      checkOutput("hold_valid", 64'(resValid), 64'd1);
      checkOutput("hold_data", 64'(resRdata), 64'(mResRdata));
    end
    applyStimulus(1'b1, 16'hBFF8, 1'b0, 32'd0, 4'd0, 1'b1);
    stepClock("release");
    checkOutput("release_valid", 64'(resValid), 64'd1);
    checkOutput("release_data", 64'(resRdata), 64'(mResRdata));
    applyStimulus(1'b0, 16'h0, 1'b0, 32'd0, 4'd0, 1'b1);
    stepClock("release_done");

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      wd = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 200));
      applyStimulus(1'($urandom_range(0, 3) != 0),
                    addrTab[$urandom_range(0, 13)] | 16'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), wd, 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 3) != 0));
      stepClock("rand");
    end

    // Reset with a response pending
    applyStimulus(1'b0, 16'h0, 1'b0, 32'd0, 4'd0, 1'b1);
    stepClock("midrst_idle");
    applyStimulus(1'b1, 16'h0004, 1'b0, 32'd0, 4'd0, 1'b0);
    stepClock("midrst_acc");
    checkOutput("midrst_pending", 64'(resValid), 64'd1);
    rst = 1'b1;
    applyStimulus(1'b0, 16'h0, 1'b0, 32'd0, 4'd0, 1'b0);
    stepClock("midrst");
    checkOutput("midrst_drop", 64'(resValid), 64'd0);
    rst = 1'b0;
    stepClock("post_rst");
    checkOutput("post_rst_rdata", 64'(resRdata), 64'd0);
    checkOutput("post_rst_err", 64'(resErr), 64'd0);
    checkOutput("post_rst_msip", 64'(msipO), 64'd0);
    checkOutput("post_rst_mtip", 64'(mtipO), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
